// File: rtl/axi_mm_read_responder.sv
// AXI4-MM read responder: queued AR bursts served from an internal beat-wide memory.
// Optional macro RD_RANGE_CHECK_EN: beats whose unwrapped beat address exceeds the memory return SLVERR.
module axi_mm_read_responder #(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 512,
  parameter int ID_W      = 5,
  parameter int MEM_DEPTH = 1024,
  parameter int AR_FIFO_D = 4
) (
  input  logic                         axis_clk,
  input  logic                         axis_rstn,
  input  logic [ID_W-1:0]              s_axi_arid,
  input  logic [ADDR_W-1:0]            s_axi_araddr,
  input  logic [7:0]                   s_axi_arlen,
  input  logic [2:0]                   s_axi_arsize,
  input  logic [1:0]                   s_axi_arburst,
  input  logic                         s_axi_arvalid,
  output logic                         s_axi_arready,
  output logic [ID_W-1:0]              s_axi_rid,
  output logic [DATA_W-1:0]            s_axi_rdata,
  output logic [1:0]                   s_axi_rresp,
  output logic                         s_axi_rlast,
  output logic                         s_axi_rvalid,
  input  logic                         s_axi_rready,
  input  logic                         bd_wr_en,
  input  logic [$clog2(MEM_DEPTH)-1:0] bd_wr_idx,
  input  logic [DATA_W-1:0]            bd_wr_data,
  output logic [31:0]                  burst_done_cnt,
  output logic                         busy
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int PTR_W = $clog2(AR_FIFO_D);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
  } ar_req_t;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_BEAT} state_t;

  ar_req_t          fifo_mem [AR_FIFO_D];
  ar_req_t          push_req, pop_req;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic             fifo_full, fifo_empty, push, pop;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [7:0]       len_q, len_d, beat_cnt_q, beat_cnt_d;
  logic             incr_q, incr_d, unsup_q, unsup_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       rresp_q, rresp_d;
  logic [31:0]      done_cnt_q, done_cnt_d;
  logic             beat_err;

  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic              unused_addr;

`ifdef RD_RANGE_CHECK_EN
  logic [ADDR_W-7:0] base_q, base_d;
  logic [ADDR_W-6:0] beat_addr;
  // Extra top bit keeps the sum from wrapping so overflow past the array is visible.
  assign beat_addr = {1'b0, base_q} + (ADDR_W-5)'(beat_cnt_q);
  assign beat_err  = unsup_q || (beat_addr >= (ADDR_W-5)'(MEM_DEPTH));
`else
  assign beat_err  = unsup_q;
`endif

  // ---------------- AR request FIFO ----------------
  assign fifo_full     = (fcnt_q == CNT_W'(AR_FIFO_D));
  assign fifo_empty    = (fcnt_q == '0);
  assign s_axi_arready = !fifo_full && !axis_rstn;
  assign push          = s_axi_arvalid && s_axi_arready;
  assign pop           = (state_q == S_IDLE) && !fifo_empty;
  assign pop_req       = fifo_mem[rd_ptr_q];
  assign unused_addr   = ^pop_req.addr;

  always_comb begin
    push_req = '{id: s_axi_arid, addr: s_axi_araddr, len: s_axi_arlen,
                 size: s_axi_arsize, burst: s_axi_arburst};
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    fcnt_d   = fcnt_q;
    if (push && !pop)      fcnt_d = fcnt_q + CNT_W'(1);
    else if (pop && !push) fcnt_d = fcnt_q - CNT_W'(1);
  end

  always_ff @(posedge axis_clk) begin
    if (push) fifo_mem[wr_ptr_q] <= push_req;
  end

  // ---------------- memory: backdoor write, registered read in LOAD ----------------
  // Old data wins when a backdoor write hits the index being loaded.
  always_ff @(posedge axis_clk) begin
    if (bd_wr_en)          mem[bd_wr_idx] <= bd_wr_data;
    if (state_q == S_LOAD) rd_data_q      <= mem[idx_q];
  end

  // ---------------- burst FSM ----------------
  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    incr_d     = incr_q;
    unsup_d    = unsup_q;
    idx_d      = idx_q;
    rresp_d    = rresp_q;
    done_cnt_d = done_cnt_q;
`ifdef RD_RANGE_CHECK_EN
    base_d     = base_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          id_d       = pop_req.id;
          len_d      = pop_req.len;
          incr_d     = (pop_req.burst == 2'b01);
          unsup_d    = (pop_req.size != 3'b110) || pop_req.burst[1];
          beat_cnt_d = '0;
          idx_d      = pop_req.addr[6 +: IDX_W];
`ifdef RD_RANGE_CHECK_EN
          base_d     = pop_req.addr[ADDR_W-1:6];
`endif
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        rresp_d = beat_err ? RESP_SLVERR : RESP_OKAY;
        state_d = S_BEAT;
      end
      S_BEAT: begin
        if (s_axi_rready) begin
          if (beat_cnt_q == len_q) begin
            done_cnt_d = done_cnt_q + 32'd1;
            state_d    = S_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
            if (incr_q) idx_d = idx_q + IDX_W'(1);
            state_d    = S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge axis_clk or posedge axis_rstn) begin
    if (axis_rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fcnt_q     <= '0;
      state_q    <= S_IDLE;
      id_q       <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      incr_q     <= 1'b0;
      unsup_q    <= 1'b0;
      idx_q      <= '0;
      rresp_q    <= RESP_OKAY;
      done_cnt_q <= '0;
`ifdef RD_RANGE_CHECK_EN
      base_q     <= '0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fcnt_q     <= fcnt_d;
      state_q    <= state_d;
      id_q       <= id_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      incr_q     <= incr_d;
      unsup_q    <= unsup_d;
      idx_q      <= idx_d;
      rresp_q    <= rresp_d;
      done_cnt_q <= done_cnt_d;
`ifdef RD_RANGE_CHECK_EN
      base_q     <= base_d;
`endif
    end
  end

  // ---------------- outputs ----------------
  assign s_axi_rvalid   = (state_q == S_BEAT);
  assign s_axi_rid      = s_axi_rvalid ? id_q : '0;
  assign s_axi_rresp    = s_axi_rvalid ? rresp_q : RESP_OKAY;
  assign s_axi_rlast    = s_axi_rvalid && (beat_cnt_q == len_q);
  assign s_axi_rdata    = (s_axi_rvalid && rresp_q == RESP_OKAY) ? rd_data_q : '0;
  assign burst_done_cnt = done_cnt_q;
  assign busy           = !fifo_empty || (state_q != S_IDLE);

endmodule

// File: tb/tb_axi_mm_read_responder.sv
// Bench for axi_mm_read_responder: directed vector table, hand-written corner sequences
// and randomized bursts scored against a beat-list reference model.
module tb_axi_mm_read_responder;
  localparam int ADDR_W = 64, DATA_W = 512, ID_W = 5, MEM_DEPTH = 1024, AR_FIFO_D = 4;

  logic              axis_clk = 0, axis_rstn = 1;
  logic [ID_W-1:0]   arid = '0;
  logic [ADDR_W-1:0] araddr = '0;
  logic [7:0]        arlen = '0;
  logic [2:0]        arsize = '0;
  logic [1:0]        arburst = '0;
  logic              arvalid = 0, arready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast, rvalid, rready = 0;
  logic              bd_wr_en = 0;
  logic [9:0]        bd_wr_idx = '0;
  logic [DATA_W-1:0] bd_wr_data = '0;
  logic [31:0]       burst_done_cnt;
  logic              busy;

  axi_mm_read_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W),
                          .MEM_DEPTH(MEM_DEPTH), .AR_FIFO_D(AR_FIFO_D)) dut (
    .axis_clk(axis_clk), .axis_rstn(axis_rstn),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .bd_wr_en(bd_wr_en), .bd_wr_idx(bd_wr_idx), .bd_wr_data(bd_wr_data),
    .burst_done_cnt(burst_done_cnt), .busy(busy));

  always #5 axis_clk = ~axis_clk;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } beat_t;

  typedef struct {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    int                n;
    logic [31:0]       first_lo, last_lo;
    logic [1:0]        first_resp, last_resp;
  } vec_t;

  logic [DATA_W-1:0] mem_m [MEM_DEPTH];
  beat_t exp_q[$], obs_q[$], got_q[$];
  int    n_checks = 0, n_fail = 0, cyc = 0, exp_done = 0, rr_mode = 0;
  vec_t  tbl[8];

  always @(posedge axis_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] pat(input int i);
    logic [DATA_W-1:0] d = '0;
    d[31:0]             = 32'hA0 + i;
    d[DATA_W-1 -: 32]   = 32'hC0DE_0000 | i;
    return d;
  endfunction

  // Reference: each accepted AR expands to len+1 expected beats from the memory model.
  function automatic void model_push(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                                     input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    longint unsigned base = addr >> 6;
    bit unsup = (size != 3'b110) || (burst != 2'b01 && burst != 2'b00);
    for (int k = 0; k <= int'(len); k++) begin
      beat_t b;
      longint unsigned ba = base + ((burst == 2'b00) ? 0 : k);
      int idx = int'(ba % MEM_DEPTH);
      bit err = unsup;
`ifdef RD_RANGE_CHECK_EN
      if (base + longint'(k) >= MEM_DEPTH) err = 1;
`endif
      b.id   = id;
      b.data = err ? '0 : mem_m[idx];
      b.resp = err ? 2'b10 : 2'b00;
      b.last = (k == int'(len));
      exp_q.push_back(b);
    end
  endfunction

  // R monitor: records handshaken beats and checks R stays frozen while stalled.
  beat_t hold;
  bit    stall_pend = 0;
  always @(negedge axis_clk) begin
    if (axis_rstn) stall_pend = 0;
    else begin
      if (stall_pend) begin
        n_checks++;
        if (!(rvalid && rid == hold.id && rdata == hold.data && rresp == hold.resp && rlast == hold.last)) begin
          n_fail++;
          $display("FAIL r_stable: got v=%0b id=%0h last=%0b expected v=1 id=%0h last=%0b",
                   rvalid, rid, rlast, hold.id, hold.last);
        end
      end
      stall_pend = rvalid && !rready;
      if (stall_pend) hold = '{id: rid, data: rdata, resp: rresp, last: rlast};
      if (rvalid && rready) obs_q.push_back('{id: rid, data: rdata, resp: rresp, last: rlast});
    end
  end

  initial forever begin
    @(posedge axis_clk); #1;
    case (rr_mode)
      0: rready = 1;
      1: rready = 0;
      2: rready = ~rready;
      default: rready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic bd_write(input int idx, input logic [DATA_W-1:0] d);
    bd_wr_en = 1; bd_wr_idx = 10'(idx); bd_wr_data = d;
    @(posedge axis_clk); #1;
    bd_wr_en = 0;
    mem_m[idx] = d;
  endtask

  // Call at posedge+1; returns at posedge+1 after the handshake edge.
  task automatic ar_send(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, output int hs_cyc);
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1;
    hs_cyc = -1;
    for (int w = 0; w < 300; w++) begin
      @(negedge axis_clk);
      if (arready) begin
        hs_cyc = cyc;
        model_push(id, addr, len, size, burst);
        break;
      end
    end
    @(posedge axis_clk); #1;
    arvalid = 0;
    if (hs_cyc < 0) chk("ar_handshake_timeout", 0, 1);
  endtask

  task automatic drain(input int budget);
    int c = 0;
    beat_t e, g;
    got_q.delete();
    while (exp_q.size() != 0 && c < budget) begin
      @(posedge axis_clk); c++;
      while (obs_q.size() != 0 && exp_q.size() != 0) begin
        g = obs_q.pop_front(); e = exp_q.pop_front(); got_q.push_back(g);
        chk("rid", g.id, e.id);
        chk("rdata", g.data, e.data);
        chk("rresp", g.resp, e.resp);
        chk("rlast", g.last, e.last);
        if (e.last) exp_done++;
      end
    end
    chk("beats_missing", exp_q.size(), 0);
    repeat (4) @(posedge axis_clk);
    chk("extra_beats", obs_q.size(), 0);
    obs_q.delete(); exp_q.delete();
    chk("burst_done_cnt", burst_done_cnt, exp_done);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs, lat, blocked;
    logic [DATA_W-1:0] nd;
    logic [1:0] rb;

    tbl[0] = '{5'd0,  64'h0,    8'd3, 3'b110, 2'b01, 4, 32'hA0,  32'hA3, 2'b00, 2'b00};
    tbl[1] = '{5'd5,  64'h47,   8'd0, 3'b110, 2'b01, 1, 32'hA1,  32'hA1, 2'b00, 2'b00};
    tbl[2] = '{5'd3,  64'h280,  8'd2, 3'b110, 2'b00, 3, 32'hAA,  32'hAA, 2'b00, 2'b00};
    tbl[3] = '{5'd7,  64'h0,    8'd1, 3'b110, 2'b10, 2, 32'h0,   32'h0,  2'b10, 2'b10};
`ifdef RD_RANGE_CHECK_EN
    tbl[4] = '{5'd1,  64'hFFC0, 8'd1, 3'b110, 2'b01, 2, 32'h49F, 32'h0,  2'b00, 2'b10};
    tbl[7] = '{5'd31, 64'hDEAD_0000_0000_00C8, 8'd0, 3'b110, 2'b01, 1, 32'h0, 32'h0, 2'b10, 2'b10};
`else
    tbl[4] = '{5'd1,  64'hFFC0, 8'd1, 3'b110, 2'b01, 2, 32'h49F, 32'hA0, 2'b00, 2'b00};
    tbl[7] = '{5'd31, 64'hDEAD_0000_0000_00C8, 8'd0, 3'b110, 2'b01, 1, 32'hA3, 32'hA3, 2'b00, 2'b00};
`endif
    tbl[5] = '{5'd2,  64'h80,   8'd0, 3'b101, 2'b01, 1, 32'h0,   32'h0,  2'b10, 2'b10};
    tbl[6] = '{5'd4,  64'hC0,   8'd2, 3'b110, 2'b11, 3, 32'h0,   32'h0,  2'b10, 2'b10};

    // Reset state
    repeat (2) @(negedge axis_clk);
    chk("rst_arready", arready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done_cnt", burst_done_cnt, 0);
    @(posedge axis_clk); #1;
    axis_rstn = 0;
    @(negedge axis_clk);
    chk("post_rst_arready", arready, 1);
    @(posedge axis_clk); #1;

    for (int i = 0; i < MEM_DEPTH; i++) bd_write(i, pat(i));

    // Directed vector table, rready held high
    for (int i = 0; i < 8; i++) begin
      ar_send(tbl[i].id, tbl[i].addr, tbl[i].len, tbl[i].size, tbl[i].burst, hs);
      if (i == 1) begin
        lat = -1;
        for (int w = 0; w < 20; w++) begin
          @(negedge axis_clk);
          if (rvalid) begin lat = cyc - hs; break; end
        end
        chk("first_rvalid_latency", lat, 3);
      end
      drain(200);
      chk("tbl_nbeats", got_q.size(), tbl[i].n);
      if (got_q.size() > 0) begin
        chk("tbl_rid", got_q[0].id, tbl[i].id);
        chk("tbl_first_data", got_q[0].data[31:0], tbl[i].first_lo);
        chk("tbl_last_data", got_q[got_q.size()-1].data[31:0], tbl[i].last_lo);
        chk("tbl_first_resp", got_q[0].resp, tbl[i].first_resp);
        chk("tbl_last_resp", got_q[got_q.size()-1].resp, tbl[i].last_resp);
        chk("tbl_rlast_final", got_q[got_q.size()-1].last, 1);
      end
    end

    // Backdoor write to the index being loaded returns the old data
    ar_send(5'd9, 64'd20 << 6, 8'd0, 3'b110, 2'b01, hs);
    @(posedge axis_clk); #1;
    nd = ~pat(20);
    bd_write(20, nd);
    drain(100);
    ar_send(5'd10, 64'd20 << 6, 8'd0, 3'b110, 2'b01, hs);
    drain(100);
    if (got_q.size() > 0) chk("bd_new_data_visible", got_q[0].data, nd);

    // FIFO fill with R stalled: one burst in service plus AR_FIFO_D queued
    rr_mode = 1;
    repeat (2) @(posedge axis_clk); #1;
    for (int i = 0; i < AR_FIFO_D + 1; i++)
      ar_send(5'(11 + i), 64'(i * 3) << 6, 8'(i), 3'b110, 2'b01, hs);
    @(negedge axis_clk);
    chk("fifo_full_arready", arready, 0);
    chk("fifo_full_busy", busy, 1);
    blocked = 0;
    repeat (6) begin @(negedge axis_clk); if (arready) blocked++; end
    chk("arready_held_low", blocked, 0);
    @(posedge axis_clk); #1;
    rr_mode = 0;
    ar_send(5'd20, 64'd50 << 6, 8'd1, 3'b110, 2'b00, hs);
    drain(400);
    chk("fifo_bursts_total", got_q.size(), 1 + 2 + 3 + 4 + 5 + 2);

    // rready toggling during a long burst
    rr_mode = 2;
    ar_send(5'd21, 64'd200 << 6, 8'd7, 3'b110, 2'b01, hs);
    drain(200);
    chk("toggle_nbeats", got_q.size(), 8);
    rr_mode = 0;

    // Randomized bursts with random rready
    for (int i = 0; i < 32; i++) bd_write(int'($urandom_range(0, MEM_DEPTH - 1)),
                                          {16{$urandom}});
    rr_mode = 3;
    for (int g = 0; g < 8; g++) begin
      for (int j = 0; j < 3; j++) begin
        rb = ($urandom_range(0, 9) < 6) ? 2'b01 : 2'($urandom_range(0, 3));
        ar_send(5'($urandom), {$urandom, $urandom}, 8'($urandom_range(0, 7)),
                ($urandom_range(0, 7) == 0) ? 3'b011 : 3'b110, rb, hs);
      end
      drain(600);
    end
    rr_mode = 0;
    repeat (2) @(posedge axis_clk); #1;

    // Reset in the middle of a stalled burst
    ar_send(5'd22, 64'd100 << 6, 8'd7, 3'b110, 2'b01, hs);
    ar_send(5'd23, 64'd300 << 6, 8'd3, 3'b110, 2'b01, hs);
    for (int w = 0; w < 50 && obs_q.size() < 2; w++) @(posedge axis_clk);
    rr_mode = 1;
    repeat (3) @(posedge axis_clk); #1;
    chk("pre_reset_rvalid", rvalid, 1);
    axis_rstn = 1;
    #1;
    chk("async_rst_rvalid", rvalid, 0);
    @(negedge axis_clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done_cnt", burst_done_cnt, 0);
    chk("mid_rst_arready", arready, 0);
    @(posedge axis_clk); #1;
    axis_rstn = 0;
    rr_mode = 0;
    exp_q.delete(); obs_q.delete(); exp_done = 0;
    @(negedge axis_clk);
    chk("after_rst_arready", arready, 1);
    @(posedge axis_clk); #1;
    ar_send(5'd24, 64'd5 << 6, 8'd2, 3'b110, 2'b01, hs);
    drain(200);
    chk("after_rst_nbeats", got_q.size(), 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
